// File: rtl/seq_tnn_stream_if.sv
// Stream handshake bundle for the sequential ternary classifier: sample in, result out.
// Latency: none, wires only.
// Backpressure: in_ready gates the sample side, out_ready gates the result side.
interface seq_tnn_stream_if #(
   parameter int FEAT_CNT   = 128,
   parameter int FEAT_BITS  = 4,
   parameter int HIDDEN_CNT = 40,
   parameter int CLASS_CNT  = 6
);
   localparam int PRED_W  = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1;
   localparam int SCORE_W = $clog2(HIDDEN_CNT) + 2;

   logic                          in_valid;
   logic                          in_ready;
   logic [FEAT_CNT*FEAT_BITS-1:0] features;
   logic                          out_valid;
   logic                          out_ready;
   logic [PRED_W-1:0]             prediction;
   logic [SCORE_W-1:0]            max_score;

   // Environment side: supplies samples and consumes results.
   modport master (
      output in_valid, features, out_ready,
      input  in_ready, out_valid, prediction, max_score
   );

   // Classifier side.
   modport slave (
      input  in_valid, features, out_ready,
      output in_ready, out_valid, prediction, max_score
   );
endinterface

// File: rtl/seq_tnn_stream.sv
// Sequential sparse ternary NN classifier: dense ternary L1, CSR-sparse L2, argmax.
// Latency: out_valid rises HIDDEN_CNT*C + NNZ2 + CLASS_CNT + 1 cycles after the accept edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no overlap.
module seq_tnn_stream #(
   parameter int FEAT_CNT        = 128,
   parameter int FEAT_BITS       = 4,
   parameter int HIDDEN_CNT      = 40,
   parameter int CLASS_CNT       = 6,
   parameter int FEATS_PER_CYCLE = 1,
   parameter logic [HIDDEN_CNT*FEAT_CNT-1:0] POS_MASK = '0,
   parameter logic [HIDDEN_CNT*FEAT_CNT-1:0] NEG_MASK = '0,
   parameter int NNZ2            = 58,
   parameter logic [((NNZ2 > 0) ? NNZ2 : 1)-1:0] SPARSE_VALS2 = '0,
   parameter logic [((NNZ2 > 0) ? NNZ2 : 1)*((HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1)-1:0]
                   COL_INDICES = '0,
   parameter logic [(CLASS_CNT+1)*((NNZ2 > 0) ? $clog2(NNZ2+1) : 1)-1:0] ROW_PTRS = '0
) (
   input  logic               clk,
   input  logic               rst,
   seq_tnn_stream_if.slave    io,
   output logic               busy
);

   localparam int C       = (FEAT_CNT + FEATS_PER_CYCLE - 1) / FEATS_PER_CYCLE;
   localparam int NNZ_W   = (NNZ2 > 0) ? NNZ2 : 1;
   localparam int CIW     = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;
   localparam int RPW     = (NNZ2 > 0) ? $clog2(NNZ2 + 1) : 1;
   localparam int ACC_W   = FEAT_BITS + $clog2(FEAT_CNT) + 2;
   localparam int SCORE_W = $clog2(HIDDEN_CNT) + 2;
   localparam int PRED_W  = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1;
   localparam int CW      = (C > 1) ? $clog2(C) : 1;
   localparam int KW      = (NNZ_W > 1) ? $clog2(NNZ_W) : 1;
   localparam int FW      = FEAT_CNT * FEAT_BITS;
   localparam int FSW     = (FW > 1) ? $clog2(FW) : 1;
   localparam int WIW     = (HIDDEN_CNT*FEAT_CNT > 1) ? $clog2(HIDDEN_CNT*FEAT_CNT) : 1;
   localparam int CSW     = (NNZ_W*CIW > 1) ? $clog2(NNZ_W*CIW) : 1;

   // A weight cannot be both +1 and -1; refuse to build such a network.
   if ((POS_MASK & NEG_MASK) != '0) begin : g_mask_check
      $error("seq_tnn_stream: POS_MASK and NEG_MASK overlap");
   end

   typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_ARGMAX, S_DONE} state_t;

   state_t                     state;
   state_t                     state_nxt;

   logic [FW-1:0]              feat_q;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    acc_nxt;
   logic signed [ACC_W-1:0]    chunk_sum;
   logic signed [ACC_W-1:0]    feat_ext;
   logic [CW-1:0]              chunk_cnt;
   logic [CIW-1:0]             neuron_cnt;
   logic [HIDDEN_CNT-1:0]      h;            // 1 = +1, 0 = -1
   int                         fi;
   logic [FSW-1:0]             fsel;
   logic [WIW-1:0]             wsel;

   logic [KW-1:0]              k_cnt;
   logic signed [SCORE_W-1:0]  score [CLASS_CNT];
   logic [RPW-1:0]             row_ptr [CLASS_CNT+1];
   logic [CSW-1:0]             csel;
   logic [CIW-1:0]             col_sel;
   logic                       row_hit;
   logic [PRED_W-1:0]          row_idx;
   logic signed [SCORE_W-1:0]  l2_delta;

   logic [PRED_W-1:0]          c_cnt;
   logic [PRED_W-1:0]          best_idx;
   logic signed [SCORE_W-1:0]  best_score;
   logic                       take;
   logic [PRED_W-1:0]          pred_q;
   logic signed [SCORE_W-1:0]  max_q;
   logic                       out_valid_q;

   logic                       accept;
   logic                       l1_last;
   logic                       l2_last;
   logic                       am_last;
   logic                       out_fire;

   assign accept   = io.in_valid && (state == S_IDLE);
   assign l1_last  = (chunk_cnt == CW'(C - 1)) && (neuron_cnt == CIW'(HIDDEN_CNT - 1));
   assign l2_last  = (k_cnt == KW'(NNZ_W - 1));
   assign am_last  = (c_cnt == PRED_W'(CLASS_CNT - 1));
   assign out_fire = out_valid_q && io.out_ready;

   assign io.in_ready   = (state == S_IDLE);
   assign io.out_valid  = out_valid_q;
   assign io.prediction = pred_q;
   assign io.max_score  = max_q;
   assign busy          = (state == S_L1) || (state == S_L2) || (state == S_ARGMAX);

   for (genvar g = 0; g <= CLASS_CNT; g++) begin : g_row_ptr
      assign row_ptr[g] = ROW_PTRS[g*RPW +: RPW];
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state: each compute phase runs for a fixed number of cycles.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (io.in_valid) state_nxt = S_L1;
         S_L1:     if (l1_last)     state_nxt = (NNZ2 > 0) ? S_L2 : S_ARGMAX;
         S_L2:     if (l2_last)     state_nxt = S_ARGMAX;
         S_ARGMAX: if (am_last)     state_nxt = S_DONE;
         S_DONE:   if (out_fire)    state_nxt = S_IDLE;
         default:                   state_nxt = S_IDLE;
      endcase
   end

   // Capture the sample only on the accept handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        feat_q <= '0;
      else if (accept) feat_q <= io.features;
   end

   // Ternary dot product of the current chunk with neuron neuron_cnt; lanes past FEAT_CNT add 0.
   always_comb begin
      chunk_sum = '0;
      feat_ext  = '0;
      fi        = 0;
      fsel      = '0;
      wsel      = '0;
      for (int p = 0; p < FEATS_PER_CYCLE; p++) begin
         fi = int'(chunk_cnt) * FEATS_PER_CYCLE + p;
         if (fi < FEAT_CNT) begin
            fsel     = FSW'(fi * FEAT_BITS);
            wsel     = WIW'(int'(neuron_cnt) * FEAT_CNT + fi);
            feat_ext = $signed({{(ACC_W-FEAT_BITS){1'b0}}, feat_q[fsel +: FEAT_BITS]});
            if (POS_MASK[wsel])      chunk_sum = chunk_sum + feat_ext;
            else if (NEG_MASK[wsel]) chunk_sum = chunk_sum - feat_ext;
         end
      end
      acc_nxt = acc + chunk_sum;
   end

   // Layer 1: accumulate chunks, then binarise the neuron sign and start the next neuron.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc        <= '0;
         chunk_cnt  <= '0;
         neuron_cnt <= '0;
         h          <= '0;
      end else if (state == S_L1) begin
         if (chunk_cnt == CW'(C - 1)) begin
            h[neuron_cnt] <= ~acc_nxt[ACC_W-1];
            acc           <= '0;
            chunk_cnt     <= '0;
            neuron_cnt    <= (neuron_cnt == CIW'(HIDDEN_CNT - 1)) ? '0 : neuron_cnt + 1'b1;
         end else begin
            acc       <= acc_nxt;
            chunk_cnt <= chunk_cnt + 1'b1;
         end
      end
   end

   // Layer 2 lookup: locate the CSR row owning nonzero k and the signed product with its hidden bit.
   always_comb begin
      csel     = CSW'(int'(k_cnt) * CIW);
      col_sel  = COL_INDICES[csel +: CIW];
      l2_delta = (SPARSE_VALS2[k_cnt] == h[col_sel]) ? SCORE_W'(1) : {SCORE_W{1'b1}};
      row_hit  = 1'b0;
      row_idx  = '0;
      for (int c = 0; c < CLASS_CNT; c++) begin
         if ((int'(k_cnt) >= int'(row_ptr[c])) && (int'(k_cnt) < int'(row_ptr[c+1]))) begin
            row_hit = 1'b1;
            row_idx = PRED_W'(c);
         end
      end
   end

   // Layer 2: scores restart from zero for every accepted sample, one nonzero per cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_cnt <= '0;
         for (int c = 0; c < CLASS_CNT; c++) score[c] <= '0;
      end else if (accept) begin
         k_cnt <= '0;
         for (int c = 0; c < CLASS_CNT; c++) score[c] <= '0;
      end else if (state == S_L2) begin
         if (row_hit) score[row_idx] <= score[row_idx] + l2_delta;
         k_cnt <= l2_last ? '0 : k_cnt + 1'b1;
      end
   end

   // Strictly-greater comparison keeps the lowest index on ties; class 0 seeds the scan.
   assign take = (c_cnt == '0) || (score[c_cnt] > best_score);

   // Argmax scan; the result registers only change when the scan completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_cnt      <= '0;
         best_idx   <= '0;
         best_score <= '0;
         pred_q     <= '0;
         max_q      <= '0;
      end else if (state == S_ARGMAX) begin
         if (take) begin
            best_idx   <= c_cnt;
            best_score <= score[c_cnt];
         end
         if (am_last) begin
            c_cnt  <= '0;
            pred_q <= take ? c_cnt : best_idx;
            max_q  <= take ? score[c_cnt] : best_score;
         end else begin
            c_cnt <= c_cnt + 1'b1;
         end
      end
   end

   // out_valid rises on the cycle after DONE is entered and drops with the handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) out_valid_q <= 1'b0;
      else      out_valid_q <= (state == S_DONE) && !out_fire;
   end

endmodule

// File: tb/tb_seq_tnn_stream.sv
// Directed bench for seq_tnn_stream: small hand-computed network plus one default-size sample.
// Latency: checks exact out_valid latency per sample.
// Backpressure: holds out_ready low in DONE and pulses in_valid to check it is ignored.
module tb_seq_tnn_stream;

   localparam int L_SMALL = 2*2 + 4 + 3 + 1;
   localparam int L_DEF   = 40*128 + 58 + 6 + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy;
   logic d_busy;
   int   tests = 0;
   int   fails = 0;
   int   lat;
   int   exp_pred;
   int   exp_max;
   logic [15:0]  f;
   logic [511:0] dfeat;

   always #5 clk = ~clk;

   seq_tnn_stream_if #(.FEAT_CNT(4), .FEAT_BITS(4), .HIDDEN_CNT(2), .CLASS_CNT(3)) s_if ();
   seq_tnn_stream_if d_if ();

   // n0 = +f0 -f1, n1 = -f2 -f3; class0 = +h0, class1 = +h0 +h1, class2 = -h1
   seq_tnn_stream #(
      .FEAT_CNT(4), .FEAT_BITS(4), .HIDDEN_CNT(2), .CLASS_CNT(3), .FEATS_PER_CYCLE(2),
      .POS_MASK(8'b0000_0001), .NEG_MASK(8'b1100_0010),
      .NNZ2(4), .SPARSE_VALS2(4'b0111), .COL_INDICES(4'b1100),
      .ROW_PTRS({3'd4, 3'd3, 3'd1, 3'd0})
   ) dut (
      .clk(clk), .rst(rst), .io(s_if), .busy(busy)
   );

   seq_tnn_stream d_dut (
      .clk(clk), .rst(rst), .io(d_if), .busy(d_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference for the small network, written directly from the weight description.
   function automatic void model(input logic [15:0] fv, output int pred, output int mx);
      int h0, h1;
      int s [3];
      h0 = (int'(fv[3:0]) - int'(fv[7:4]) >= 0) ? 1 : -1;
      h1 = (-int'(fv[11:8]) - int'(fv[15:12]) >= 0) ? 1 : -1;
      s[0] = h0;
      s[1] = h0 + h1;
      s[2] = -h1;
      pred = 0;
      mx   = s[0];
      for (int c = 1; c < 3; c++) if (s[c] > mx) begin pred = c; mx = s[c]; end
   endfunction

   // Offer a sample, then count cycles from the accept edge until out_valid (bounded).
   task automatic run_small(input logic [15:0] fv, output int cycles);
      chk("accept_in_ready", s_if.in_ready, 1);
      s_if.features = fv;
      s_if.in_valid = 1'b1;
      tick();
      s_if.in_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("in_ready_after_accept", s_if.in_ready, 0);
      cycles = 0;
      while (!s_if.out_valid && cycles < 100) begin
         tick();
         cycles++;
      end
   endtask

   initial begin
      s_if.in_valid  = 1'b0;
      s_if.features  = '0;
      s_if.out_ready = 1'b1;
      d_if.in_valid  = 1'b0;
      d_if.features  = '0;
      d_if.out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_in_ready", s_if.in_ready, 1);
      chk("rst_out_valid", s_if.out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_prediction", s_if.prediction, 0);
      chk("rst_max_score", $signed(s_if.max_score), 0);
      rst = 1'b1;
      tick();

      // Basic: {5,3,0,0} -> scores {1,2,-1}
      run_small(16'h0035, lat);
      chk("basic_latency", lat, L_SMALL);
      chk("basic_pred", s_if.prediction, 1);
      chk("basic_max", $signed(s_if.max_score), 2);
      tick();
      chk("basic_in_ready_after", s_if.in_ready, 1);
      chk("basic_out_valid_after", s_if.out_valid, 0);

      // Negative: {0,9,4,4} -> scores {-1,-2,1}
      run_small(16'h4490, lat);
      chk("neg_latency", lat, L_SMALL);
      chk("neg_pred", s_if.prediction, 2);
      chk("neg_max", $signed(s_if.max_score), 1);
      tick();

      // Tie: {1,1,0,1} -> scores {1,0,1}, lowest index wins
      run_small(16'h1011, lat);
      chk("tie_latency", lat, L_SMALL);
      chk("tie_pred", s_if.prediction, 0);
      chk("tie_max", $signed(s_if.max_score), 1);
      tick();

      // Backpressure: result held, new samples refused
      s_if.out_ready = 1'b0;
      run_small(16'h0035, lat);
      chk("bp_latency", lat, L_SMALL);
      for (int i = 0; i < 20; i++) begin
         s_if.features = 16'h4490;
         s_if.in_valid = (i % 3) != 2;
         tick();
         chk("bp_out_valid", s_if.out_valid, 1);
         chk("bp_in_ready", s_if.in_ready, 0);
         chk("bp_pred", s_if.prediction, 1);
         chk("bp_max", $signed(s_if.max_score), 2);
      end
      s_if.in_valid  = 1'b0;
      s_if.out_ready = 1'b1;
      tick();
      chk("bp_release_in_ready", s_if.in_ready, 1);
      chk("bp_release_out_valid", s_if.out_valid, 0);

      // Reset mid-L2: aborts asynchronously, next sample runs normally
      s_if.features = 16'h0035;
      s_if.in_valid = 1'b1;
      tick();
      s_if.in_valid = 1'b0;
      repeat (6) tick();
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", s_if.in_ready, 1);
      chk("midrst_out_valid", s_if.out_valid, 0);
      chk("midrst_busy", busy, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("postrst_out_valid", s_if.out_valid, 0);
      run_small(16'h4490, lat);
      chk("postrst_latency", lat, L_SMALL);
      chk("postrst_pred", s_if.prediction, 2);
      chk("postrst_max", $signed(s_if.max_score), 1);
      tick();

      // Random samples against the reference
      for (int n = 0; n < 12; n++) begin
         f = 16'($urandom());
         model(f, exp_pred, exp_max);
         run_small(f, lat);
         chk("rand_latency", lat, L_SMALL);
         chk("rand_pred", s_if.prediction, exp_pred);
         chk("rand_max", $signed(s_if.max_score), exp_max);
         tick();
      end

      // Default configuration: zero weights give all-zero scores, class 0 wins
      for (int i = 0; i < 16; i++) dfeat[i*32 +: 32] = $urandom();
      chk("def_in_ready", d_if.in_ready, 1);
      d_if.features = dfeat;
      d_if.in_valid = 1'b1;
      tick();
      d_if.in_valid = 1'b0;
      lat = 0;
      while (!d_if.out_valid && lat < L_DEF + 100) begin
         tick();
         lat++;
      end
      chk("def_latency", lat, L_DEF);
      chk("def_pred", d_if.prediction, 0);
      chk("def_max", $signed(d_if.max_score), 0);
      tick();
      chk("def_in_ready_after", d_if.in_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
